// File: rtl/ae_pipeline_scheduler.sv
// Control sequencer for the 3-stage arithmetic-encoder datapath: symbol valid/ready intake,
// downstream stall, tile start/done framing and a saturating accepted-symbol count.
module ae_pipeline_scheduler #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   general_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   stall,
  output logic                   pipeline_reg_1_2,
  output logic                   pipeline_reg_2_3,
  output logic                   pipeline_reg_final,
  output logic                   mux_start,
  output logic                   state_init,
  output logic                   tile_done,
  output logic [COUNT_WIDTH-1:0] sym_count,
  output logic                   count_ovf
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  state_t state;
  logic   vld_p1;
  logic   vld_p2;
  logic   active;
  logic   advance;
  logic   fire;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The pipeline only moves while a tile is in flight and downstream can take data;
  // reset suppresses every enable so an aborted tile never reaches the final register.
  assign active             = (state == RUN) || (state == DRAIN);
  assign advance            = active && !stall && !reset;
  assign in_ready           = (state == RUN) && !stall && !reset;
  assign fire               = in_valid && in_ready;
  assign pipeline_reg_1_2   = advance;
  assign pipeline_reg_2_3   = advance;
  assign pipeline_reg_final = advance && vld_p2;
  // With a live symbol in stage 3 the previous result is still on the forward path.
  assign mux_start          = !vld_p2;

  always_ff @(posedge general_clk) begin
    if (reset) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      sym_count  <= '0;
      count_ovf  <= 1'b0;
      state_init <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      state_init <= 1'b0;
      tile_done  <= 1'b0;

      // stage 1 -> stage 2 -> final register valid tracking
      if (advance) begin
        vld_p1 <= fire;
        vld_p2 <= vld_p1;
      end

      if (fire) begin
        sym_count <= sat_inc(sym_count);
        if (&sym_count) count_ovf <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= INIT;
            state_init <= 1'b1;
            sym_count  <= '0;
            count_ovf  <= 1'b0;
          end
        end
        INIT: state <= RUN;
        RUN: begin
          if (fire && in_last) state <= DRAIN;
        end
        DRAIN: begin
          // Leaving now means stage 1 empties and stage 3 is written on this same edge.
          if (advance && !vld_p1) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ae_pipeline_scheduler.sv
// Bench for ae_pipeline_scheduler: a toy range/low datapath driven by the scheduler's enables,
// checked against a serial golden model through scoreboard queues.
module tb_ae_pipeline_scheduler;

  logic general_clk = 1'b0;
  logic reset, start, in_valid, in_last, stall;
  logic [7:0] in_sym;

  logic        in_ready, pipeline_reg_1_2, pipeline_reg_2_3, pipeline_reg_final;
  logic        mux_start, state_init, tile_done, count_ovf;
  logic [15:0] sym_count;

  logic        b_in_ready, b_reg_1_2, b_reg_2_3, b_reg_final, b_mux_start, b_state_init, b_tile_done;
  logic        b_count_ovf;
  logic [1:0]  b_sym_count;

  ae_pipeline_scheduler #(.COUNT_WIDTH(16)) dut (
    .general_clk(general_clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .stall(stall),
    .pipeline_reg_1_2(pipeline_reg_1_2), .pipeline_reg_2_3(pipeline_reg_2_3),
    .pipeline_reg_final(pipeline_reg_final), .mux_start(mux_start), .state_init(state_init),
    .tile_done(tile_done), .sym_count(sym_count), .count_ovf(count_ovf)
  );

  ae_pipeline_scheduler #(.COUNT_WIDTH(2)) dut_w2 (
    .general_clk(general_clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_last(in_last), .in_ready(b_in_ready), .stall(stall),
    .pipeline_reg_1_2(b_reg_1_2), .pipeline_reg_2_3(b_reg_2_3),
    .pipeline_reg_final(b_reg_final), .mux_start(b_mux_start), .state_init(b_state_init),
    .tile_done(b_tile_done), .sym_count(b_sym_count), .count_ovf(b_count_ovf)
  );

  always #5 general_clk = ~general_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  always @(posedge general_clk) cyc <= cyc + 1;

  localparam logic [47:0] INIT_ST = {16'd32768, 32'd0};

  function automatic logic [47:0] upd(input logic [47:0] st, input logic [7:0] s);
    logic [15:0] r;
    logic [31:0] l;
    r = st[47:32] - {2'b00, s, 6'b000000};
    l = st[31:0] + {24'd0, s};
    return {r, l};
  endfunction

  function automatic logic [47:0] renorm(input logic [47:0] st);
    logic [15:0] r;
    logic [31:0] l;
    r = st[47:32];
    l = st[31:0];
    if (r < 16'd16384) begin
      r = r << 1;
      l = l << 1;
    end
    return {r, l};
  endfunction

  // Toy datapath slaved to the scheduler's enables and mux select
  logic [7:0]  s1_sym;
  logic [47:0] s2_st, s3_st, fin_st, src_st;
  assign s3_st  = renorm(s2_st);
  assign src_st = mux_start ? fin_st : s3_st;
  always @(posedge general_clk) begin
    if (pipeline_reg_1_2) s1_sym <= in_sym;
    if (pipeline_reg_2_3) s2_st <= upd(src_st, s1_sym);
    if (state_init) fin_st <= INIT_ST;
    else if (pipeline_reg_final) fin_st <= s3_st;
  end

  logic [47:0] gold;
  logic [47:0] exp_q[$];
  int          done_edge_q[$];
  int          done_cnt_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes the final register or ends a tile
  always @(negedge general_clk) begin
    if (pipeline_reg_final) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL final_write_unexpected actual=%0h required=no_write", s3_st);
      end else begin
        check("final_state", 64'(s3_st), 64'(exp_q.pop_front()));
      end
    end
    if (tile_done) begin
      if (done_edge_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tile_done_unexpected actual=1 required=0 cyc=%0d", cyc);
      end else begin
        check("tile_done_cycle", 64'(cyc), 64'(done_edge_q.pop_front()));
        check("tile_done_count", 64'(sym_count), 64'(done_cnt_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge general_clk);
    #1;
  endtask

  task automatic note_accept(input logic [7:0] s);
    gold = renorm(upd(gold, s));
    exp_q.push_back(gold);
    last_acc = cyc + 1;
  endtask

  task automatic send(input logic [7:0] s, input logic last);
    int n = 0;
    in_valid = 1'b1; in_sym = s; in_last = last;
    forever begin
      @(negedge general_clk);
      if (in_ready) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    if (in_ready) note_accept(s);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_tile();
    gold  = INIT_ST;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("state_init_pulse", 64'(state_init), 64'd1);
    check("init_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("state_init_once", 64'(state_init), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_edge_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (done_edge_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL tile_done_timeout pending=%0d required=0", done_edge_q.size());
      done_edge_q.delete();
      done_cnt_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  syms [4];
    logic [7:0]  ready_seq, mux_seq, fin_seq;
    logic [47:0] snap;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; stall = 1'b0; in_sym = 8'h00;
    gold = INIT_ST;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mux_start", 64'(mux_start), 64'd1);
    check("rst_reg_1_2", 64'(pipeline_reg_1_2), 64'd0);
    check("rst_reg_final", 64'(pipeline_reg_final), 64'd0);
    check("rst_state_init", 64'(state_init), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_sym_count", 64'(sym_count), 64'd0);
    check("rst_count_ovf", 64'(count_ovf), 64'd0);

    // Four back-to-back symbols, cycle-by-cycle control profile
    start_tile();
    syms = '{8'h11, 8'hc3, 8'h5a, 8'hff};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_sym = syms[i]; in_last = (i == 3);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge general_clk);
      if (i < 4 && in_ready) begin
        note_accept(syms[i]);
        if (i == 3) begin
          done_edge_q.push_back(last_acc + 2);
          done_cnt_q.push_back(4);
        end
      end
      ready_seq[i] = in_ready;
      mux_seq[i]   = mux_start;
      fin_seq[i]   = pipeline_reg_final;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("b2b_in_ready_seq", 64'(ready_seq), 64'(8'b0000_1111));
    check("b2b_mux_start_seq", 64'(mux_seq), 64'(8'b1100_0011));
    check("b2b_reg_final_seq", 64'(fin_seq), 64'(8'b0011_1100));
    check("b2b_sym_count", 64'(sym_count), 64'd4);
    check("b2b_fin_state", 64'(fin_st), 64'(gold));

    // Symbols separated by one and two bubbles
    start_tile();
    send(8'h21, 1'b0);
    idle(1);
    send(8'h9c, 1'b0);
    idle(2);
    send(8'hff, 1'b0);
    idle(1);
    send(8'h07, 1'b1);
    done_edge_q.push_back(last_acc + 2);
    done_cnt_q.push_back(4);
    wait_done();
    check("bubble_fin_state", 64'(fin_st), 64'(gold));

    // Stall in RUN with a pending symbol, then in DRAIN with both stages live
    start_tile();
    send(8'h40, 1'b0);
    send(8'h81, 1'b0);
    stall = 1'b1; in_valid = 1'b1; in_sym = 8'h33; in_last = 1'b0;
    snap = fin_st;
    for (int i = 0; i < 3; i++) begin
      @(negedge general_clk);
      check("stall_run_in_ready", 64'(in_ready), 64'd0);
      check("stall_run_reg_1_2", 64'(pipeline_reg_1_2), 64'd0);
      check("stall_run_reg_2_3", 64'(pipeline_reg_2_3), 64'd0);
      tick();
    end
    stall = 1'b0;
    send(8'h33, 1'b0);
    send(8'hee, 1'b1);
    done_edge_q.push_back(last_acc + 2 + 3);
    done_cnt_q.push_back(4);
    stall = 1'b1;
    snap = fin_st;
    for (int i = 0; i < 3; i++) begin
      @(negedge general_clk);
      check("stall_drain_reg_final", 64'(pipeline_reg_final), 64'd0);
      check("stall_drain_mux_start", 64'(mux_start), 64'd0);
      tick();
      check("stall_drain_fin_hold", 64'(fin_st), 64'(snap));
    end
    stall = 1'b0;
    wait_done();
    check("stall_fin_state", 64'(fin_st), 64'(gold));

    // Single-symbol tile
    start_tile();
    send(8'h5e, 1'b1);
    done_edge_q.push_back(last_acc + 2);
    done_cnt_q.push_back(1);
    wait_done();
    check("single_sym_count", 64'(sym_count), 64'd1);

    // Counter saturation on the 2-bit instance
    start_tile();
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h10 + i), i == 4);
      check("w2_sym_count", 64'(b_sym_count), 64'((i < 3) ? i + 1 : 3));
      check("w2_count_ovf", 64'(b_count_ovf), 64'(i >= 3));
    end
    done_edge_q.push_back(last_acc + 2);
    done_cnt_q.push_back(5);
    wait_done();
    check("w2_ovf_sticky", 64'(b_count_ovf), 64'd1);
    start_tile();
    check("w2_ovf_cleared", 64'(b_count_ovf), 64'd0);
    check("w2_count_cleared", 64'(b_sym_count), 64'd0);

    // Reset while draining a live symbol in stage 3
    send(8'h77, 1'b1);
    tick();
    reset = 1'b1;
    @(negedge general_clk);
    check("rst_drain_reg_final", 64'(pipeline_reg_final), 64'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst_drain_in_ready", 64'(in_ready), 64'd0);
    check("rst_drain_mux_start", 64'(mux_start), 64'd1);
    check("rst_drain_sym_count", 64'(sym_count), 64'd0);
    check("rst_drain_tile_done", 64'(tile_done), 64'd0);
    @(negedge general_clk);
    check("rst_drain_idle_final", 64'(pipeline_reg_final), 64'd0);
    repeat (5) tick();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("done_q_empty", 64'(done_edge_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
